// File: rtl/second_game_controller_if.sv
// ---------------------------------------------------------------------------
// second_game_controller_if
//
// Bundles the per-pixel and per-frame signals exchanged between the second
// game controller and the video/input front end.
//
//   i_frame_tick       one-cycle pulse per video frame
//   i_start            start/restart request (level)
//   i_left / i_right   move buttons (level)
//   i_disp_enbl        display enable for the current pixel
//   i_h_coord          current horizontal pixel (11 bits)
//   i_v_coord          current vertical pixel (10 bits)
//   i_is_obstacle      obstacle map hit for the current pixel
//   o_screen_square_x  player centre x in field coordinates
//   o_scroll_offset    obstacle map vertical offset
//   o_score            frames survived
//   o_lives            remaining lives
//   o_state            IDLE=0, PLAY=1, HIT=2, OVER=3
//   o_game_over        high while in OVER
//
// The master modport is the front end (drives the inputs). The slave modport
// is the controller.
// ---------------------------------------------------------------------------
interface second_game_controller_if #(
   parameter int SECOND_GAME_SCREEN_WIDTH  = 400,
   parameter int SECOND_GAME_SCREEN_HEIGHT = 600
);
   localparam int X_W = $clog2(SECOND_GAME_SCREEN_WIDTH);
   localparam int Y_W = $clog2(SECOND_GAME_SCREEN_HEIGHT);

   logic           i_frame_tick;
   logic           i_start;
   logic           i_left;
   logic           i_right;
   logic           i_disp_enbl;
   logic [10:0]    i_h_coord;
   logic [9:0]     i_v_coord;
   logic           i_is_obstacle;
   logic [X_W-1:0] o_screen_square_x;
   logic [Y_W-1:0] o_scroll_offset;
   logic [15:0]    o_score;
   logic [1:0]     o_lives;
   logic [1:0]     o_state;
   logic           o_game_over;

   modport master (
      output i_frame_tick, i_start, i_left, i_right, i_disp_enbl,
             i_h_coord, i_v_coord, i_is_obstacle,
      input  o_screen_square_x, o_scroll_offset, o_score, o_lives,
             o_state, o_game_over
   );

   modport slave (
      input  i_frame_tick, i_start, i_left, i_right, i_disp_enbl,
             i_h_coord, i_v_coord, i_is_obstacle,
      output o_screen_square_x, o_scroll_offset, o_score, o_lives,
             o_state, o_game_over
   );
endinterface

// File: rtl/second_game_controller.sv
// ---------------------------------------------------------------------------
// second_game_controller
//
// Game-state controller for a vertical-scroller dodge game. The player box
// moves horizontally once per frame. The obstacle map scrolls underneath it.
// A collision is detected pixel by pixel while the beam is inside the player
// box, and it is acted on at the next frame tick. After a hit the game
// freezes for HIT_FRAMES frames. It then resumes, or it ends once no lives
// remain.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   bus      second_game_controller_if.slave (see the interface for fields)
//
// Every output is a register. It updates on the clock edge after the
// qualifying input.
// ---------------------------------------------------------------------------
module second_game_controller #(
   parameter int SECOND_GAME_START_X       = 400,
   parameter int SECOND_GAME_SCREEN_WIDTH  = 400,
   parameter int SECOND_GAME_SCREEN_HEIGHT = 600,
   parameter int SECOND_GAME_PLAYER_SIZE   = 20,
   parameter int MOVE_STEP                 = 4,
   parameter int SCROLL_STEP               = 2,
   parameter int HIT_FRAMES                = 60,
   parameter int START_LIVES               = 3
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   second_game_controller_if.slave bus
);

   localparam int X_W   = $clog2(SECOND_GAME_SCREEN_WIDTH);
   localparam int X_W1  = X_W + 1;
   localparam int Y_W   = $clog2(SECOND_GAME_SCREEN_HEIGHT);
   localparam int Y_W1  = Y_W + 1;
   localparam int CNT_W = (HIT_FRAMES > 0) ? $clog2(HIT_FRAMES + 1) : 1;

   localparam logic [X_W-1:0]   X_HOME    = X_W'(SECOND_GAME_SCREEN_WIDTH / 2);
   localparam logic [X_W-1:0]   X_MIN     = X_W'(SECOND_GAME_PLAYER_SIZE);
   localparam logic [X_W-1:0]   X_MAX     = X_W'(SECOND_GAME_SCREEN_WIDTH - 1 - SECOND_GAME_PLAYER_SIZE);
   localparam logic [X_W-1:0]   X_STEP    = X_W'(MOVE_STEP);
   localparam logic [Y_W-1:0]   Y_STEP    = Y_W'(SCROLL_STEP);
   localparam logic [Y_W1-1:0]  Y_HEIGHT  = Y_W1'(SECOND_GAME_SCREEN_HEIGHT);
   localparam logic [9:0]       V_LIMIT   = 10'(SECOND_GAME_PLAYER_SIZE / 2 + SECOND_GAME_PLAYER_SIZE);
   localparam logic [11:0]      START_X12 = 12'(SECOND_GAME_START_X);
   localparam logic [11:0]      SIZE12    = 12'(SECOND_GAME_PLAYER_SIZE);
   localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [1:0]       LIVES0    = 2'(START_LIVES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } state_t;

   state_t           state;
   logic [X_W-1:0]   pos_x;
   logic [Y_W-1:0]   scroll;
   logic [15:0]      score;
   logic [1:0]       lives;
   logic             hit_latch;
   logic [CNT_W-1:0] hit_count;
   logic             game_over;

   logic signed [11:0] rel_h;
   logic signed [11:0] box_lo;
   logic signed [11:0] box_hi;
   logic               hit_now;
   logic [X_W-1:0]     x_moved;
   logic [Y_W1-1:0]    scroll_sum;
   logic [Y_W-1:0]     scroll_next;
   logic [15:0]        score_next;

   // Pixel-level collision test. The beam position is converted to field
   // coordinates as a signed value, so pixels left of the field origin come
   // out negative and can never fall inside the box. Only the top rows of the
   // field, where the player box is drawn, are considered.
   always_comb begin
      rel_h   = $signed({1'b0, bus.i_h_coord}) - $signed(START_X12);
      box_lo  = $signed(12'(pos_x)) - $signed(SIZE12);
      box_hi  = $signed(12'(pos_x)) + $signed(SIZE12);
      hit_now = (state == PLAY) && bus.i_disp_enbl && bus.i_is_obstacle &&
                (rel_h >= box_lo) && (rel_h <= box_hi) &&
                (bus.i_v_coord <= V_LIMIT);
   end

   // Candidate per-frame movement. The sums are widened by one bit so the
   // clamp against the field edges cannot be defeated by wraparound.
   always_comb begin
      x_moved = pos_x;
      if (bus.i_left && !bus.i_right) begin
         if (X_W1'(pos_x) < (X_W1'(X_MIN) + X_W1'(X_STEP)))
            x_moved = X_MIN;
         else
            x_moved = pos_x - X_STEP;
      end else if (bus.i_right && !bus.i_left) begin
         if ((X_W1'(pos_x) + X_W1'(X_STEP)) > X_W1'(X_MAX))
            x_moved = X_MAX;
         else
            x_moved = pos_x + X_STEP;
      end
   end

   // Scroll wraps modulo the field height. The score saturates rather than
   // rolling over.
   always_comb begin
      scroll_sum  = Y_W1'(scroll) + Y_W1'(Y_STEP);
      scroll_next = (scroll_sum >= Y_HEIGHT) ? Y_W'(scroll_sum - Y_HEIGHT)
                                             : scroll_sum[Y_W-1:0];
      score_next  = (score == 16'hFFFF) ? score : score + 16'd1;
   end

   // Main game FSM. IDLE continuously reloads the starting values, so a
   // restart from OVER only has to return to IDLE. The collision latch
   // remembers a hit seen anywhere during the frame until the next tick acts
   // on it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         pos_x     <= X_HOME;
         scroll    <= '0;
         score     <= '0;
         lives     <= LIVES0;
         hit_latch <= 1'b0;
         hit_count <= '0;
         game_over <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pos_x     <= X_HOME;
               scroll    <= '0;
               score     <= '0;
               lives     <= LIVES0;
               hit_latch <= 1'b0;
               hit_count <= '0;
               game_over <= 1'b0;
               if (bus.i_start)
                  state <= PLAY;
            end
            PLAY: begin
               if (bus.i_frame_tick) begin
                  hit_latch <= 1'b0;
                  if (hit_latch || hit_now) begin
                     state     <= HIT;
                     lives     <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                     hit_count <= HIT_LOAD;
                  end else begin
                     pos_x  <= x_moved;
                     scroll <= scroll_next;
                     score  <= score_next;
                  end
               end else if (hit_now) begin
                  hit_latch <= 1'b1;
               end
            end
            HIT: begin
               hit_latch <= 1'b0;
               if (bus.i_frame_tick) begin
                  if (hit_count <= CNT_ONE) begin
                     hit_count <= '0;
                     if (lives == 2'd0) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                     end else begin
                        state <= PLAY;
                     end
                  end else begin
                     hit_count <= hit_count - CNT_ONE;
                  end
               end
            end
            OVER: begin
               hit_latch <= 1'b0;
               if (bus.i_start) begin
                  state     <= IDLE;
                  pos_x     <= X_HOME;
                  scroll    <= '0;
                  score     <= '0;
                  lives     <= LIVES0;
                  hit_count <= '0;
                  game_over <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_screen_square_x = pos_x;
   assign bus.o_scroll_offset   = scroll;
   assign bus.o_score           = score;
   assign bus.o_lives           = lives;
   assign bus.o_state           = state;
   assign bus.o_game_over       = game_over;

endmodule
